// File: rtl/neighbor_reader_if.sv
// Query / neighbor-stream / status bundle between neighbor_reader and its consumer.
// slave is the responder side, master the requester/consumer side.
interface neighbor_reader_if;
  logic        query_valid;
  logic        query_ready;
  logic [8:0]  query_vertex;
  logic        nbr_valid;
  logic        nbr_ready;
  logic [31:0] nbr_vertex;
  logic        nbr_last;
  logic [3:0]  nbr_count;
  logic        done;
  logic        err;
  logic        busy;

  modport slave (
    input  query_valid, query_vertex, nbr_ready,
    output query_ready, nbr_valid, nbr_vertex, nbr_last, nbr_count, done, err, busy
  );
  modport master (
    output query_valid, query_vertex, nbr_ready,
    input  query_ready, nbr_valid, nbr_vertex, nbr_last, nbr_count, done, err, busy
  );
endinterface

// File: rtl/neighbor_reader.sv
// Fetches one vertex's neighbor list from the neighbor RAM and streams it out
// through a 2-entry FIFO, keeping reads-in-flight plus FIFO entries at most 2.
module neighbor_reader #(
  parameter int MAX_NEIGHBOR_COUNT = 10
) (
  input  logic               clk,
  input  logic               rst,
  neighbor_reader_if.slave   bus,
  output logic               RAM_NBR_EN,
  output logic [8:0]         RAM_NBR_A,
  output logic [3:0]         RAM_NBR_WE,
  output logic [31:0]        RAM_NBR_Di,
  input  logic [31:0]        RAM_NBR_Do
);
  typedef enum logic [1:0] {IDLE, RD_COUNT, STREAM, DONE} state_t;
  localparam logic [3:0] MAXC = 4'(MAX_NEIGHBOR_COUNT);

  state_t      state, state_n;
  logic [8:0]  base;
  logic [3:0]  cnt, issued;
  logic        rd_vld, rd_last;
  logic [31:0] fifo_data [2];
  logic [1:0]  fifo_last;
  logic        rd_ptr, wr_ptr;
  logic [1:0]  occ;

  logic        accept, pop, range_bad, issue, issue_last, done_d, last_pop;
  logic [12:0] base_full;
  logic [3:0]  cnt_raw, cnt_clamp, cnt_eff;

  assign RAM_NBR_WE = 4'b0000;
  assign RAM_NBR_Di = 32'd0;

  // Head of FIFO drives the stream directly.
  assign bus.nbr_valid  = (occ != 2'd0);
  assign bus.nbr_vertex = fifo_data[rd_ptr];
  assign bus.nbr_last   = fifo_last[rd_ptr] & bus.nbr_valid;

  assign accept   = (state == IDLE) && bus.query_valid && bus.query_ready;
  assign pop      = bus.nbr_valid && bus.nbr_ready;
  assign last_pop = pop && fifo_last[rd_ptr];

  // Full-width product so large vertex indices cannot wrap into range.
  assign base_full = (13'(bus.query_vertex) - 13'd1) * 13'(MAX_NEIGHBOR_COUNT);
  assign range_bad = (bus.query_vertex == 9'd0) ||
                     ((14'(base_full) + 14'(MAX_NEIGHBOR_COUNT)) > 14'd511);

  assign cnt_raw   = RAM_NBR_Do[3:0];
  assign cnt_clamp = (cnt_raw > MAXC) ? MAXC : cnt_raw;
  assign cnt_eff   = (state == RD_COUNT) ? cnt_clamp : cnt;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (accept) state_n = range_bad ? DONE : RD_COUNT;
      RD_COUNT: state_n = (cnt_clamp == 4'd0) ? DONE : STREAM;
      STREAM:   if (last_pop) state_n = IDLE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    issue      = 1'b0;
    issue_last = ((issued + 4'd1) == cnt_eff);
    done_d     = (state == DONE) || ((state == STREAM) && last_pop);
    case (state)
      RD_COUNT: issue = (cnt_clamp != 4'd0);
      // A read issued now lands next cycle; leave room after this cycle's push/pop.
      STREAM:   issue = (issued < cnt) &&
                        ((3'(occ) + 3'(rd_vld)) < (3'd2 + 3'(pop)));
      default:  issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      base            <= '0;
      cnt             <= '0;
      issued          <= '0;
      rd_vld          <= 1'b0;
      rd_last         <= 1'b0;
      for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
      fifo_last       <= '0;
      rd_ptr          <= 1'b0;
      wr_ptr          <= 1'b0;
      occ             <= '0;
      RAM_NBR_EN      <= 1'b0;
      RAM_NBR_A       <= '0;
      bus.query_ready <= 1'b0;
      bus.nbr_count   <= '0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      state           <= state_n;
      RAM_NBR_EN      <= 1'b1;
      bus.query_ready <= (state == IDLE) && (state_n == IDLE);
      bus.done        <= done_d;

      if (accept) begin
        base          <= base_full[8:0];
        issued        <= '0;
        bus.err       <= range_bad;
        bus.nbr_count <= '0;
        bus.busy      <= 1'b1;
        if (!range_bad) RAM_NBR_A <= base_full[8:0];
      end
      if (state == RD_COUNT) begin
        cnt           <= cnt_clamp;
        bus.nbr_count <= cnt_clamp;
        if (cnt_raw > MAXC) bus.err <= 1'b1;
      end
      if (done_d) bus.busy <= 1'b0;

      rd_vld <= issue;
      if (issue) begin
        RAM_NBR_A <= base + 9'(issued) + 9'd1;
        issued    <= issued + 4'd1;
        rd_last   <= issue_last;
      end

      if (rd_vld) begin
        fifo_data[wr_ptr] <= RAM_NBR_Do;
        fifo_last[wr_ptr] <= rd_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= 2'(occ + 2'(rd_vld) - 2'(pop));
    end
  end
endmodule

// File: tb/tb_neighbor_reader.sv
// Bench for neighbor_reader: directed table, hand-written reset/backpressure
// sequences and random queries scored against a list-level model of the RAM.
module tb_neighbor_reader;
  localparam int MAXN = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en;
  logic [8:0]  ram_a;
  logic [3:0]  ram_we;
  logic [31:0] ram_di, ram_do;
  logic [31:0] mem [512];

  int checks = 0;
  int errors = 0;

  int          m_cnt;
  bit          m_err, m_range;
  logic [31:0] m_beats [$];

  typedef struct {
    int qv;
    int mode;
    int cnt;
    bit err;
    int lat;
  } vec_t;
  vec_t vecs [8];

  neighbor_reader_if bus();

  neighbor_reader #(.MAX_NEIGHBOR_COUNT(MAXN)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .RAM_NBR_EN(ram_en), .RAM_NBR_A(ram_a), .RAM_NBR_WE(ram_we),
    .RAM_NBR_Di(ram_di), .RAM_NBR_Do(ram_do)
  );

  always #5 clk = ~clk;
  assign ram_do = mem[ram_a];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Expected list for a query, straight from the addressing rules.
  task automatic model(input int qv);
    int base, raw;
    m_beats.delete();
    m_range = (qv == 0) || ((qv - 1) * MAXN + MAXN > 511);
    m_err   = m_range;
    m_cnt   = 0;
    if (!m_range) begin
      base  = (qv - 1) * MAXN;
      raw   = int'(mem[base][3:0]);
      m_cnt = (raw > MAXN) ? MAXN : raw;
      if (raw > MAXN) m_err = 1'b1;
      for (int i = 0; i < m_cnt; i++) m_beats.push_back(mem[base + 1 + i]);
    end
  endtask

  // mode: 0 ready high, 1 pattern 1,0,0,1,0,1, 2 random, 3 low 12 cycles then high
  task automatic run_query(input int qv, input int mode, input int exp_cnt,
                           input bit exp_err, input int exp_lat);
    int e, bi, wait_n, done_e;
    logic [8:0] a_idle;
    bit a_moved, pv, pr, pl, rdy;
    logic [31:0] pvx;
    model(qv);
    wait_n = 0;
    while (bus.query_ready !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    chk("query_ready_wait", bus.query_ready, 1);
    a_idle = ram_a;
    bus.query_valid  = 1'b1;
    bus.query_vertex = 9'(qv);
    @(posedge clk);
    @(negedge clk);
    bus.query_valid = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    e = 0; bi = 0; done_e = -1; a_moved = 0;
    pv = 0; pr = 0; pl = 0; pvx = '0;
    while (e < 400) begin
      if (ram_a !== a_idle) a_moved = 1;
      if (pv && !pr) begin
        chk("stall_valid", bus.nbr_valid, 1);
        chk("stall_vertex", bus.nbr_vertex, pvx);
        chk("stall_last", bus.nbr_last, pl);
      end
      if (bus.done === 1'b1) begin
        done_e = e;
        break;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (e % 6 == 0) || (e % 6 == 3) || (e % 6 == 5);
        2:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (e >= 12);
      endcase
      bus.nbr_ready = rdy;
      if (bus.nbr_valid === 1'b1 && rdy) begin
        if (bi < m_cnt) begin
          chk("beat_vertex", bus.nbr_vertex, m_beats[bi]);
          chk("beat_last", bus.nbr_last, (bi == m_cnt - 1));
        end else begin
          chk("extra_beat", bi, m_cnt);
        end
        bi++;
      end
      pv = bus.nbr_valid; pr = rdy; pvx = bus.nbr_vertex; pl = bus.nbr_last;
      @(posedge clk);
      @(negedge clk);
      e++;
    end
    bus.nbr_ready = 1'b0;
    chk("done_seen", (done_e >= 0), 1);
    if (exp_lat >= 0) chk("done_latency", done_e, exp_lat);
    chk("beat_count", bi, m_cnt);
    chk("nbr_count", bus.nbr_count, exp_cnt);
    chk("err", bus.err, exp_err);
    chk("busy_at_done", bus.busy, 0);
    if (m_range) chk("ram_addr_unchanged", a_moved, 0);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("query_ready_back", bus.query_ready, 1);
  endtask

  initial begin
    int qv, dn;
    bus.query_valid  = 1'b0;
    bus.query_vertex = '0;
    bus.nbr_ready    = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[0]  = 32'd0;
    mem[10] = 32'h1234_567F;
    mem[20] = 32'd3;
    mem[21] = 32'd7; mem[22] = 32'd2; mem[23] = 32'd9;
    mem[40] = 32'd5;
    mem[500] = 32'hABCD_000A;

    vecs[0] = '{qv: 3,  mode: 0, cnt: 3,  err: 0, lat: 5};
    vecs[1] = '{qv: 1,  mode: 0, cnt: 0,  err: 0, lat: 2};
    vecs[2] = '{qv: 2,  mode: 0, cnt: 10, err: 1, lat: 12};
    vecs[3] = '{qv: 0,  mode: 0, cnt: 0,  err: 1, lat: 1};
    vecs[4] = '{qv: 52, mode: 0, cnt: 0,  err: 1, lat: 1};
    vecs[5] = '{qv: 51, mode: 0, cnt: 10, err: 0, lat: 12};
    vecs[6] = '{qv: 3,  mode: 1, cnt: 3,  err: 0, lat: -1};
    vecs[7] = '{qv: 3,  mode: 3, cnt: 3,  err: 0, lat: -1};

    repeat (2) @(negedge clk);
    chk("rst_query_ready", bus.query_ready, 0);
    chk("rst_nbr_valid", bus.nbr_valid, 0);
    chk("rst_nbr_last", bus.nbr_last, 0);
    chk("rst_nbr_vertex", bus.nbr_vertex, 0);
    chk("rst_nbr_count", bus.nbr_count, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("ram_we", ram_we, 0);
    chk("ram_di", ram_di, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_query_ready", bus.query_ready, 1);
    chk("idle_ram_en", ram_en, 1);

    for (int v = 0; v < 8; v++)
      run_query(vecs[v].qv, vecs[v].mode, vecs[v].cnt, vecs[v].err, vecs[v].lat);

    // Abort a 5-neighbor stream with a one-cycle reset.
    while (bus.query_ready !== 1'b1) @(negedge clk);
    bus.query_valid  = 1'b1;
    bus.query_vertex = 9'd5;
    @(posedge clk);
    @(negedge clk);
    bus.query_valid = 1'b0;
    bus.nbr_ready   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_nbr_valid", bus.nbr_valid, 0);
    chk("abort_nbr_last", bus.nbr_last, 0);
    chk("abort_nbr_vertex", bus.nbr_vertex, 0);
    chk("abort_nbr_count", bus.nbr_count, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_err", bus.err, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ram_a", ram_a, 0);
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.nbr_valid === 1'b1) dn++;
    end
    chk("abort_no_done_or_beat", dn, 0);
    bus.nbr_ready = 1'b0;
    run_query(3, 0, 3, 0, 5);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 9) == 0) qv = $urandom_range(52, 511);
      else qv = $urandom_range(0, 54);
      model(qv);
      run_query(qv, 2, m_cnt, m_err, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
